// File: rtl/rc5_pkg.sv
// RC5-32/12 shared definitions: word size, rounds, FSM encoding and the
// subkey table expanded from the all-zero 16-byte key (shared with encrypt).
package rc5_pkg;

    localparam int W    = 32;
    localparam int R    = 12;
    localparam int NSUB = 2 * R + 2;

    localparam logic [31:0] P32 = 32'hB7E1_5163;
    localparam logic [31:0] Q32 = 32'h9E37_79B9;

    typedef logic [NSUB-1:0][31:0] s_tab_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL
    } state_e;

    function automatic logic [31:0] rotr(logic [31:0] x, logic [4:0] n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    function automatic logic [31:0] rotl(logic [31:0] x, logic [4:0] n);
        return rotr(x, 5'd0 - n);
    endfunction

    // Evaluated at elaboration only; the table lands in the design as constants.
    function automatic s_tab_t expand_zero_key();
        s_tab_t           s;
        logic [3:0][31:0] l;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [31:0]      ab;
        int               ii;
        int               jj;
        s[0] = P32;
        for (int k = 1; k < NSUB; k++) begin
            s[k] = s[k-1] + Q32;
        end
        l  = '0;
        a  = '0;
        b  = '0;
        ii = 0;
        jj = 0;
        for (int k = 0; k < 3 * NSUB; k++) begin
            a     = rotl(s[ii] + a + b, 5'd3);
            s[ii] = a;
            ab    = a + b;
            b     = rotl(l[jj] + ab, ab[4:0]);
            l[jj] = b;
            ii    = (ii + 1) % NSUB;
            jj    = (jj + 1) % 4;
        end
        return s;
    endfunction

    localparam s_tab_t S_TAB = expand_zero_key();

endpackage

// File: rtl/rc5_dec_round.sv
// One combinational RC5 decryption round.
// Ports: a_i/b_i current words, s_a_i = S[2i], s_b_i = S[2i+1]; a_o/b_o next words.
module rc5_dec_round
    import rc5_pkg::*;
#(
    parameter int W = rc5_pkg::W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] s_a_i,
    input  logic [W-1:0] s_b_i,
    output logic [W-1:0] a_o,
    output logic [W-1:0] b_o
);

    logic [W-1:0] b_new;

    // B is undone first; A then rotates by the freshly recovered B.
    always_comb begin
        b_new = rotr(b_i - s_b_i, a_i[4:0]) ^ a_i;
        b_o   = b_new;
        a_o   = rotr(a_i - s_a_i, b_new[4:0]) ^ b_new;
    end

endmodule

// File: rtl/rc5_decrypt.sv
// Iterative RC5-32/12 block decryptor, one round per clock.
// Ports: clk, clr (async high), din/di_vld/di_rdy in, dout/do_rdy out.
module rc5_decrypt
    import rc5_pkg::*;
#(
    parameter int W = rc5_pkg::W,
    parameter int R = rc5_pkg::R
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [2*W-1:0] din,
    input  logic           di_vld,
    output logic           di_rdy,
    output logic [2*W-1:0] dout,
    output logic           do_rdy
);

    localparam int IW = $clog2(R + 1);

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [IW-1:0]  i_q, i_d;
    logic [2*W-1:0] dout_q, dout_d;
    logic           do_rdy_q, do_rdy_d;

    logic [IW:0]    idx_a;
    logic [IW:0]    idx_b;
    logic [W-1:0]   s_a;
    logic [W-1:0]   s_b;
    logic [W-1:0]   a_nx;
    logic [W-1:0]   b_nx;

    // Round i consumes the subkey pair S[2i], S[2i+1].
    always_comb begin
        idx_a = {i_q, 1'b0};
        idx_b = {i_q, 1'b1};
        s_a   = S_TAB[idx_a];
        s_b   = S_TAB[idx_b];
    end

    rc5_dec_round #(
        .W(W)
    ) u_round (
        .a_i  (a_q),
        .b_i  (b_q),
        .s_a_i(s_a),
        .s_b_i(s_b),
        .a_o  (a_nx),
        .b_o  (b_nx)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        i_d      = i_q;
        dout_d   = dout_q;
        do_rdy_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (di_vld) begin
                    a_d     = din[W-1:0];
                    b_d     = din[2*W-1:W];
                    i_d     = IW'(R);
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                a_d = a_nx;
                b_d = b_nx;
                i_d = i_q - 1'b1;
                if (i_q == IW'(1)) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                dout_d   = {b_q - S_TAB[1], a_q - S_TAB[0]};
                do_rdy_d = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            i_q      <= '0;
            dout_q   <= '0;
            do_rdy_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            i_q      <= i_d;
            dout_q   <= dout_d;
            do_rdy_q <= do_rdy_d;
        end
    end

    assign di_rdy = (state_q == ST_IDLE);
    assign dout   = dout_q;
    assign do_rdy = do_rdy_q;

endmodule

// File: tb/tb_rc5_decrypt.sv
// Self-checking bench for rc5_decrypt against a behavioural RC5-32/12 model
// (own key schedule, encrypt and decrypt) with randomized blocks.
module tb_rc5_decrypt;

    localparam int RR = 12;

    logic        clk = 1'b0;
    logic        clr;
    logic [63:0] din;
    logic        di_vld;
    logic        di_rdy;
    logic [63:0] dout;
    logic        do_rdy;

    int n_chk  = 0;
    int n_fail = 0;

    bit [31:0] sk [26];

    rc5_decrypt u_dut (
        .clk   (clk),
        .clr   (clr),
        .din   (din),
        .di_vld(di_vld),
        .di_rdy(di_rdy),
        .dout  (dout),
        .do_rdy(do_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit [31:0] m_rol(bit [31:0] x, bit [31:0] n);
        int k;
        k = int'(n % 32);
        if (k == 0) return x;
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic bit [31:0] m_ror(bit [31:0] x, bit [31:0] n);
        int k;
        k = int'(n % 32);
        if (k == 0) return x;
        return (x >> k) | (x << (32 - k));
    endfunction

    task automatic m_keysched();
        bit [31:0] l [4];
        bit [31:0] a, b;
        int ii, jj;
        sk[0] = 32'hB7E15163;
        for (int k = 1; k < 26; k++) sk[k] = sk[k-1] + 32'h9E3779B9;
        for (int k = 0; k < 4; k++) l[k] = 0;
        a = 0; b = 0; ii = 0; jj = 0;
        for (int k = 0; k < 78; k++) begin
            a = m_rol(sk[ii] + a + b, 3);
            sk[ii] = a;
            b = m_rol(l[jj] + a + b, a + b);
            l[jj] = b;
            ii = (ii + 1) % 26;
            jj = (jj + 1) % 4;
        end
    endtask

    function automatic bit [63:0] m_enc(bit [63:0] p);
        bit [31:0] a, b;
        a = p[31:0] + sk[0];
        b = p[63:32] + sk[1];
        for (int i = 1; i <= RR; i++) begin
            a = m_rol(a ^ b, b) + sk[2*i];
            b = m_rol(b ^ a, a) + sk[2*i+1];
        end
        return {b, a};
    endfunction

    function automatic bit [63:0] m_dec(bit [63:0] c);
        bit [31:0] a, b;
        a = c[31:0];
        b = c[63:32];
        for (int i = RR; i >= 1; i--) begin
            b = m_ror(b - sk[2*i+1], a) ^ a;
            a = m_ror(a - sk[2*i], b) ^ b;
        end
        return {b - sk[1], a - sk[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic run_block(input string tag, input logic [63:0] c,
                             input logic [63:0] exp);
        int  lat;
        bit  seen;
        for (int k = 0; k < 20 && !di_rdy; k++) tick();
        din    = c;
        di_vld = 1'b1;
        tick();
        di_vld = 1'b0;
        din    = rnd64();
        seen   = 1'b0;
        lat    = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            tick();
            if (do_rdy) begin
                seen = 1'b1;
                lat  = k;
            end
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no do_rdy expected one", tag);
        end else begin
            chk({tag, "_lat"}, 64'(lat), 64'(RR + 1));
            chk({tag, "_dout"}, dout, exp);
        end
    endtask

    initial begin
        logic [63:0] p, c, d0, d14, held;
        bit          exp_r;

        m_keysched();
        clr    = 1'b1;
        din    = '0;
        di_vld = 1'b0;
        #23;
        chk("rst_di_rdy", 64'(di_rdy), 64'd1);
        chk("rst_do_rdy", 64'(do_rdy), 64'd0);
        chk("rst_dout", dout, 64'd0);
        @(negedge clk);
        clr = 1'b0;
        tick();

        run_block("known", 64'h6D8F4B15_EEDBA521, 64'h0);
        run_block("rtrip", m_enc(64'h1), 64'h1);

        for (int n = 0; n < 8; n++) begin
            p = rnd64();
            run_block("rand", m_enc(p), p);
        end

        c = {$urandom(), 32'h00000020};
        run_block("rot_a0", c, m_dec(c));
        c = {$urandom(), 32'h0000001F};
        run_block("rot_a31", c, m_dec(c));
        c = {32'h00000020, 32'h0000001F};
        run_block("rot_mix", c, m_dec(c));
        c = {32'h0000001F, 32'hFFFFFFE0};
        run_block("rot_mix2", c, m_dec(c));

        held = dout;
        for (int k = 0; k < 50; k++) begin
            tick();
            chk("idle_do_rdy", 64'(do_rdy), 64'd0);
            chk("idle_dout", dout, held);
        end

        d0  = '0;
        d14 = '0;
        for (int k = 0; k < 28; k++) begin
            din    = rnd64();
            di_vld = 1'b1;
            if (k == 0)  d0  = din;
            if (k == 14) d14 = din;
            tick();
            exp_r = (k == 13) || (k == 27);
            chk("busy_do_rdy", 64'(do_rdy), 64'(exp_r));
            if (k == 13) chk("busy_first", dout, m_dec(d0));
            if (k == 27) chk("busy_second", dout, m_dec(d14));
        end
        di_vld = 1'b0;
        tick();

        p      = rnd64();
        din    = m_enc(p);
        di_vld = 1'b1;
        tick();
        di_vld = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        #2;
        clr = 1'b1;
        #1;
        chk("abort_di_rdy", 64'(di_rdy), 64'd1);
        chk("abort_do_rdy", 64'(do_rdy), 64'd0);
        chk("abort_dout", dout, 64'd0);
        @(negedge clk);
        clr = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("abort_quiet", 64'(do_rdy), 64'd0);
        end
        p = rnd64();
        run_block("after_abort", m_enc(p), p);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
